prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that fills the CPU's 16-bit instruction memory before execution and holds the CPU off until a valid image is in place. It sits between a byte source (UART receiver or test host) and the instruction-memory write port. It drives the memory-side write strobes, the counterpart of the control unit's instruction reads. Frames carry a magic byte, a word count, big-endian instruction words and an XOR checksum.

## Interface
- ADDR_W, 8, instruction-memory address width; maximum image size is 2^ADDR_W words, capped at 255 by the count byte.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; forces the reset values below.
- start  in  1  one-cycle pulse; opens a load session.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle; transfer occurs when rx_valid & rx_ready at the clock edge.
- imem_addr  out  ADDR_W  instruction-memory write address.
- imem_wdata  out  16  instruction word, {high byte, low byte}.
- imem_we  out  1  one-cycle write strobe.
- cpu_hold  out  1  high keeps the CPU in reset/halted; low releases it.
- done  out  1  one-cycle pulse at end of session, on success or failure.
- error  out  1  sticky failure flag; cleared by start or reset.
- words_loaded  out  ADDR_W+1  words written in the current session.

## Operation
- States: IDLE, MAGIC, COUNT, HI, LO, CHECK, FINISH.
- Reset values: state IDLE, cpu_hold=1, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, words_loaded=0, checksum=0.
- IDLE, on start:
  - go to MAGIC;
  - clear error, words_loaded, address and checksum;
  - set cpu_hold=1.
- start in any non-IDLE state aborts the session and restarts identically. Words already written stay in memory.
- MAGIC: accepted byte 0xA5 goes to COUNT. Any other byte is discarded and the loader stays in MAGIC (resync). No error is raised.
- COUNT:
  - latch N = byte; checksum = byte.
  - N > 2^ADDR_W: set error, go to FINISH.
  - N = 0: go to CHECK.
  - Otherwise go to HI.
- HI: latch the high byte, checksum ^= byte, go to LO.
- LO:
  - checksum ^= byte;
  - register imem_wdata={hi,lo} and imem_addr=current address, and pulse imem_we the next cycle;
  - increment address and words_loaded;
  - if words_loaded reaches N, go to CHECK, else go to HI.
- CHECK: accepted byte compared to the running checksum. A mismatch sets error. Either way, go to FINISH.
- FINISH (one cycle):
  - done=1;
  - cpu_hold = error;
  - return to IDLE.
- Checksum: 8-bit XOR over the count byte and all data bytes. The magic and checksum bytes are excluded.
- rx_ready: 1 in MAGIC, COUNT, HI, LO, CHECK; 0 in IDLE, FINISH.
- Address wraps only by construction; N is bounded so address never exceeds N-1.

## Timing
- One byte per cycle is sustainable; rx_ready never drops mid-frame.
- imem_we is high exactly one cycle, the cycle after the LO byte is accepted. imem_addr and imem_wdata are stable in that cycle.
- done rises the cycle after the checksum byte is accepted, or the cycle after a rejected count byte.
- cpu_hold falls in the same cycle as done on success, and stays 1 on error.
- error is valid from the done cycle and holds until the next start or reset.
- Reset asserted mid-frame: all outputs return to reset values immediately. Any partially assembled word is dropped and no write is issued.
- start and rx_valid in the same cycle: start wins; the byte is not consumed.

## Test plan
- Reset, then idle 10 cycles -> cpu_hold=1, rx_ready=0, imem_we=0, done=0, error=0.
- start; bytes A5 02 12 34 AB CD 42 back-to-back ->
  - writes addr0=0x1234, then addr1=0xABCD, each a single-cycle imem_we;
  - done pulse; error=0, cpu_hold=0, words_loaded=2.
- Same frame with checksum 0x43 -> both writes occur, done pulse, error=1, cpu_hold=1. Next start clears error.
- start; bytes 00 FF A5 00 00 -> leading bytes ignored, no imem_we, done pulse, error=0, cpu_hold=0.
- start; A5 02 12, then reset low for 2 cycles -> all outputs reset, no write issued. A full frame after a fresh start writes from addr 0.
- ADDR_W=4; start; A5 11 -> done pulse the cycle after the count byte, error=1, no imem_we, rx_ready=0 in FINISH.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader
//   Byte-stream program loader for the 16-bit instruction memory. It accepts
//   frames of the form
//       A5 | N | {hi,lo} x N | xor-checksum
//   writes each big-endian word to consecutive instruction-memory addresses
//   starting at 0, and keeps the CPU held until a frame with a correct
//   checksum has been loaded.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   start         one-cycle pulse, opens (or restarts) a load session
//   rx_data       incoming byte
//   rx_valid      rx_data valid this cycle
//   rx_ready      loader accepts a byte this cycle
//   imem_addr     instruction-memory write address
//   imem_wdata    instruction word {high byte, low byte}
//   imem_we       one-cycle write strobe
//   cpu_hold      high keeps the CPU halted
//   done          one-cycle pulse at the end of a session
//   error         sticky failure flag, cleared by start or reset
//   words_loaded  words written in the current session
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              imem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    // Comparison width: strictly wider than both the count byte and the
    // words_loaded counter, so zero-extension always has at least one pad bit.
    localparam int CW = ((ADDR_W > 8) ? ADDR_W : 8) + 2;

    localparam logic [CW-1:0]     MAX_WORDS = {{(CW-1){1'b0}}, 1'b1} << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WL_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [7:0]        MAGIC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAGIC  = 3'd1,
        COUNT  = 3'd2,
        HI     = 3'd3,
        LO     = 3'd4,
        CHECK  = 3'd5,
        FINISH = 3'd6
    } state_t;

    // Running frame checksum: XOR of the count byte and every data byte.
    function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                               input logic [7:0] data_byte);
        return csum ^ data_byte;
    endfunction

    state_t            state_r,        state_nxt_s;
    logic [CW-1:0]     count_r,        count_nxt_s;
    logic [7:0]        hi_r,           hi_nxt_s;
    logic [7:0]        csum_r,         csum_nxt_s;
    logic [ADDR_W-1:0] addr_r,         addr_nxt_s;
    logic [ADDR_W:0]   wl_r,           wl_nxt_s;
    logic [ADDR_W-1:0] imem_addr_r,    imem_addr_nxt_s;
    logic [15:0]       imem_wdata_r,   imem_wdata_nxt_s;
    logic              imem_we_r,      imem_we_nxt_s;
    logic              cpu_hold_r,     cpu_hold_nxt_s;
    logic              done_r,         done_nxt_s;
    logic              error_r,        error_nxt_s;
    logic              rx_ready_r,     rx_ready_nxt_s;

    logic              accept_s;
    logic [ADDR_W:0]   wl_inc_s;
    logic [CW-1:0]     wl_inc_ext_s;
    logic [CW-1:0]     rx_ext_s;

    // start has priority over a byte offered in the same cycle.
    assign accept_s     = rx_valid & rx_ready_r & ~start;
    assign wl_inc_s     = wl_r + WL_ONE;
    assign wl_inc_ext_s = {{(CW-ADDR_W-1){1'b0}}, wl_inc_s};
    assign rx_ext_s     = {{(CW-8){1'b0}}, rx_data};

    // Next-state and next-register values for the load sequencer.
    always_comb begin
        state_nxt_s      = state_r;
        count_nxt_s      = count_r;
        hi_nxt_s         = hi_r;
        csum_nxt_s       = csum_r;
        addr_nxt_s       = addr_r;
        wl_nxt_s         = wl_r;
        imem_addr_nxt_s  = imem_addr_r;
        imem_wdata_nxt_s = imem_wdata_r;
        imem_we_nxt_s    = 1'b0;
        cpu_hold_nxt_s   = cpu_hold_r;
        error_nxt_s      = error_r;
        done_nxt_s       = 1'b0;
        rx_ready_nxt_s   = 1'b0;

        if (start) begin
            state_nxt_s    = MAGIC;
            error_nxt_s    = 1'b0;
            wl_nxt_s       = '0;
            addr_nxt_s     = '0;
            csum_nxt_s     = 8'h00;
            cpu_hold_nxt_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                MAGIC: begin
                    // Anything but the magic byte is dropped silently (resync).
                    if (accept_s && (rx_data == MAGIC_BYTE)) begin
                        state_nxt_s = COUNT;
                    end else begin
                        state_nxt_s = MAGIC;
                    end
                end
                COUNT: begin
                    if (accept_s) begin
                        count_nxt_s = rx_ext_s;
                        csum_nxt_s  = rx_data;
                        if (rx_ext_s > MAX_WORDS) begin
                            error_nxt_s = 1'b1;
                            state_nxt_s = FINISH;
                        end else if (rx_data == 8'h00) begin
                            state_nxt_s = CHECK;
                        end else begin
                            state_nxt_s = HI;
                        end
                    end else begin
                        state_nxt_s = COUNT;
                    end
                end
                HI: begin
                    if (accept_s) begin
                        hi_nxt_s    = rx_data;
                        csum_nxt_s  = csum_update(csum_r, rx_data);
                        state_nxt_s = LO;
                    end else begin
                        state_nxt_s = HI;
                    end
                end
                LO: begin
                    if (accept_s) begin
                        csum_nxt_s       = csum_update(csum_r, rx_data);
                        imem_wdata_nxt_s = {hi_r, rx_data};
                        imem_addr_nxt_s  = addr_r;
                        imem_we_nxt_s    = 1'b1;
                        addr_nxt_s       = addr_r + ADDR_ONE;
                        wl_nxt_s         = wl_inc_s;
                        if (wl_inc_ext_s == count_r) begin
                            state_nxt_s = CHECK;
                        end else begin
                            state_nxt_s = HI;
                        end
                    end else begin
                        state_nxt_s = LO;
                    end
                end
                CHECK: begin
                    if (accept_s) begin
                        if (rx_data != csum_r) begin
                            error_nxt_s = 1'b1;
                        end else begin
                            error_nxt_s = error_r;
                        end
                        state_nxt_s = FINISH;
                    end else begin
                        state_nxt_s = CHECK;
                    end
                end
                FINISH: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end

        // done and the CPU release coincide with the FINISH cycle.
        if (state_nxt_s == FINISH) begin
            done_nxt_s     = 1'b1;
            cpu_hold_nxt_s = error_nxt_s;
        end else begin
            done_nxt_s     = 1'b0;
        end

        case (state_nxt_s)
            MAGIC, COUNT, HI, LO, CHECK: rx_ready_nxt_s = 1'b1;
            default:                     rx_ready_nxt_s = 1'b0;
        endcase
    end

    // State and datapath registers; every output is driven from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            count_r      <= '0;
            hi_r         <= 8'h00;
            csum_r       <= 8'h00;
            addr_r       <= '0;
            wl_r         <= '0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 16'h0000;
            imem_we_r    <= 1'b0;
            cpu_hold_r   <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            rx_ready_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            hi_r         <= hi_nxt_s;
            csum_r       <= csum_nxt_s;
            addr_r       <= addr_nxt_s;
            wl_r         <= wl_nxt_s;
            imem_addr_r  <= imem_addr_nxt_s;
            imem_wdata_r <= imem_wdata_nxt_s;
            imem_we_r    <= imem_we_nxt_s;
            cpu_hold_r   <= cpu_hold_nxt_s;
            done_r       <= done_nxt_s;
            error_r      <= error_nxt_s;
            rx_ready_r   <= rx_ready_nxt_s;
        end
    end

    assign rx_ready     = rx_ready_r;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = imem_wdata_r;
    assign imem_we      = imem_we_r;
    assign cpu_hold     = cpu_hold_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = wl_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: an ADDR_W=8 instance exercises the
// normal frame paths, an ADDR_W=4 instance exercises the oversize count.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    logic        rx_ready, imem_we, cpu_hold, done, error;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [8:0]  words_loaded;

    logic        rx_ready4, imem_we4, cpu_hold4, done4, error4;
    logic [3:0]  imem_addr4;
    logic [15:0] imem_wdata4;
    logic [4:0]  words_loaded4;

    int checks = 0;
    int errors = 0;

    logic [23:0] wr_log [$];
    int          we_double = 0;
    logic        we_prev = 1'b0;
    int          wr4_cnt = 0;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    prog_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready4),
        .imem_addr(imem_addr4), .imem_wdata(imem_wdata4), .imem_we(imem_we4),
        .cpu_hold(cpu_hold4), .done(done4), .error(error4),
        .words_loaded(words_loaded4)
    );

    // Write monitor: logs every strobe and flags strobes longer than a cycle.
    always @(negedge clk) begin
        if (imem_we) wr_log.push_back({imem_addr, imem_wdata});
        if (imem_we && we_prev) we_double++;
        we_prev <= imem_we;
        if (imem_we4) wr4_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start4();
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    // Offer one byte for exactly one clock edge; returns on the next negedge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        // ---- reset and idle ----
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("idle_we",       {31'd0, imem_we},  32'd0);
        chk("idle_done",     {31'd0, done},     32'd0);
        chk("idle_error",    {31'd0, error},    32'd0);
        chk("idle_wl",       {23'd0, words_loaded}, 32'd0);
        chk("idle4_hold",    {31'd0, cpu_hold4}, 32'd1);

        // ---- good two-word frame ----
        wr_log.delete();
        pulse_start();
        chk("sess_rx_ready", {31'd0, rx_ready}, 32'd1);
        send(8'hA5); send(8'h02); send(8'h12); send(8'h34);
        send(8'hAB); send(8'hCD); send(8'h42);
        chk("good_done",     {31'd0, done},     32'd1);
        chk("good_error",    {31'd0, error},    32'd0);
        chk("good_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("good_wl",       {23'd0, words_loaded}, 32'd2);
        chk("good_fin_rdy",  {31'd0, rx_ready}, 32'd0);
        chk("good_nwr",      wr_log.size(), 32'd2);
        if (wr_log.size() == 2) begin
            chk("good_wr0", {8'd0, wr_log[0]}, 32'h00_00_1234);
            chk("good_wr1", {8'd0, wr_log[1]}, 32'h00_01_ABCD);
        end
        @(negedge clk);
        chk("good_done_low", {31'd0, done},     32'd0);
        chk("good_hold_low", {31'd0, cpu_hold}, 32'd0);

        // ---- same frame, bad checksum ----
        wr_log.delete();
        pulse_start();
        chk("bad_start_hold", {31'd0, cpu_hold}, 32'd1);
        send(8'hA5); send(8'h02); send(8'h12); send(8'h34);
        send(8'hAB); send(8'hCD); send(8'h43);
        chk("bad_done",     {31'd0, done},     32'd1);
        chk("bad_error",    {31'd0, error},    32'd1);
        chk("bad_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("bad_nwr",      wr_log.size(), 32'd2);
        @(negedge clk);
        chk("bad_sticky",   {31'd0, error},    32'd1);

        // ---- start clears error; resync on leading junk, empty image ----
        wr_log.delete();
        pulse_start();
        chk("clr_error", {31'd0, error}, 32'd0);
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h00); send(8'h00);
        chk("empty_done",  {31'd0, done},     32'd1);
        chk("empty_error", {31'd0, error},    32'd0);
        chk("empty_hold",  {31'd0, cpu_hold}, 32'd0);
        chk("empty_nwr",   wr_log.size(), 32'd0);

        // ---- reset mid-frame ----
        wr_log.delete();
        pulse_start();
        send(8'hA5); send(8'h02); send(8'h12);
        reset = 1'b0;
        #1;
        chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);
        chk("rst_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_we",    {31'd0, imem_we},  32'd0);
        chk("rst_addr",  {24'd0, imem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, imem_wdata}, 32'd0);
        chk("rst_error", {31'd0, error},    32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_nwr", wr_log.size(), 32'd0);
        pulse_start();
        send(8'hA5); send(8'h01); send(8'hBE); send(8'hEF); send(8'h50);
        chk("rst2_done",  {31'd0, done},  32'd1);
        chk("rst2_error", {31'd0, error}, 32'd0);
        chk("rst2_nwr",   wr_log.size(), 32'd1);
        if (wr_log.size() == 1) chk("rst2_wr0", {8'd0, wr_log[0]}, 32'h00_00_BEEF);

        // ---- start wins over a byte in the same cycle ----
        wr_log.delete();
        pulse_start();
        send(8'hA5);
        rx_data = 8'h05; rx_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b0;
        send(8'h05);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h07); send(8'h06);
        chk("sw_done",  {31'd0, done},  32'd1);
        chk("sw_error", {31'd0, error}, 32'd0);
        chk("sw_nwr",   wr_log.size(), 32'd1);
        if (wr_log.size() == 1) chk("sw_wr0", {8'd0, wr_log[0]}, 32'h00_00_0007);
        chk("we_single", we_double, 32'd0);

        // ---- oversize count on the ADDR_W=4 instance ----
        pulse_start4();
        send(8'hA5); send(8'h11);
        chk("ovf_done",  {31'd0, done4},     32'd1);
        chk("ovf_error", {31'd0, error4},    32'd1);
        chk("ovf_hold",  {31'd0, cpu_hold4}, 32'd1);
        chk("ovf_ready", {31'd0, rx_ready4}, 32'd0);
        @(negedge clk);
        chk("ovf_done_low", {31'd0, done4}, 32'd0);
        chk("ovf_nwr", wr4_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
